// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: FSM state encoding and encoded-grant width helper.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_REFRESH = 2'd2
    } sched_state_t;

    function automatic int port_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a pending flag and a late pulse
// when an interval expires while the previous refresh is still outstanding.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 1560
) (
    input  logic sdram_clk,
    input  logic sdram_rst,
    input  logic refresh_ack_i,
    output logic pending_o,
    output logic late_o
);

    localparam int TW = $clog2(REFRESH_CYCLES);

    logic [TW-1:0] r_cnt;
    logic          r_pending;
    logic          r_late;
    logic          w_expire;

    assign w_expire = (r_cnt == '0);

    // Expiry wins over a same-cycle ack so a fresh interval is never lost.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            r_cnt     <= TW'(REFRESH_CYCLES - 1);
            r_pending <= 1'b0;
            r_late    <= 1'b0;
        end else begin
            r_late <= w_expire && r_pending;
            if (w_expire) begin
                r_cnt     <= TW'(REFRESH_CYCLES - 1);
                r_pending <= 1'b1;
            end else begin
                r_cnt <= r_cnt - TW'(1);
                if (refresh_ack_i)
                    r_pending <= 1'b0;
            end
        end
    end

    assign pending_o = r_pending;
    assign late_o    = r_late;

endmodule

// File: rtl/sdram_port_sched.sv
// Round-robin owner scheduler for the SDRAM controller with quota and refresh injection.
// Define SDRAM_SCHED_PRIO0_EN to give port 0 fixed priority and quota immunity.
module sdram_port_sched
    import sdram_sched_pkg::*;
#(
    parameter int WB_PORTS       = 3,
    parameter int QUOTA          = 16,
    parameter int REFRESH_CYCLES = 1560,
    localparam int PORT_W        = port_w(WB_PORTS)
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic [WB_PORTS-1:0] req_i,
    input  logic                ack_i,
    input  logic                sdram_idle_i,
    input  logic                refresh_ack_i,
    output logic [WB_PORTS-1:0] grant_o,
    output logic [PORT_W-1:0]   grant_enc_o,
    output logic                grant_valid_o,
    output logic                refresh_o,
    output logic                refresh_late_o
);

    localparam int CNT_W = (QUOTA < 1) ? 1 : $clog2(QUOTA + 1);

    sched_state_t        r_state, w_state_nxt;
    logic [WB_PORTS-1:0] r_grant, w_grant_nxt;
    logic [PORT_W-1:0]   r_enc, w_enc_nxt;
    logic [PORT_W-1:0]   r_last, w_last_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [PORT_W-1:0]   w_pick;
    logic                w_pending;
    logic                w_others_req;
    logic                w_quota_yield;
    logic                w_release;

    sdram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .sdram_clk     (sdram_clk),
        .sdram_rst     (sdram_rst),
        .refresh_ack_i (refresh_ack_i),
        .pending_o     (w_pending),
        .late_o        (refresh_late_o)
    );

    // First requester after `last`, wrapping; port 0 bypasses the rotation when prioritised.
    function automatic logic [PORT_W-1:0] rr_pick(input logic [WB_PORTS-1:0] req,
                                                  input logic [PORT_W-1:0]   last);
        logic [WB_PORTS-1:0] req_m;
        logic                found;
        int                  idx;
        rr_pick = '0;
        found   = 1'b0;
        req_m   = req;
`ifdef SDRAM_SCHED_PRIO0_EN
        if (req[0])
            found = 1'b1;
        req_m[0] = 1'b0;
`endif
        for (int i = 1; i <= WB_PORTS; i++) begin
            idx = int'(last) + i;
            if (idx >= WB_PORTS)
                idx = idx - WB_PORTS;
            if (!found && req_m[idx[PORT_W-1:0]]) begin
                rr_pick = PORT_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign w_pick       = rr_pick(req_i, r_last);
    assign w_others_req = |(req_i & ~r_grant);

`ifdef SDRAM_SCHED_PRIO0_EN
    assign w_quota_yield = (QUOTA != 0) && (r_count >= CNT_W'(QUOTA)) && w_others_req
                           && (r_enc != '0);
`else
    assign w_quota_yield = (QUOTA != 0) && (r_count >= CNT_W'(QUOTA)) && w_others_req;
`endif

    assign w_release = sdram_idle_i && (!req_i[r_enc] || w_pending || w_quota_yield);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_enc_nxt   = r_enc;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_pending && sdram_idle_i) begin
                    w_state_nxt = ST_REFRESH;
                end else if (|req_i) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = WB_PORTS'(1) << w_pick;
                    w_enc_nxt   = w_pick;
                    w_count_nxt = '0;
                end
            end
            ST_OWN: begin
                if (ack_i && (QUOTA != 0) && (r_count < CNT_W'(QUOTA)))
                    w_count_nxt = r_count + CNT_W'(1);
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
`ifdef SDRAM_SCHED_PRIO0_EN
                    if (r_enc != '0)
                        w_last_nxt = r_enc;
`else
                    w_last_nxt = r_enc;
`endif
                end
            end
            ST_REFRESH: begin
                if (refresh_ack_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_enc   <= '0;
            r_last  <= PORT_W'(WB_PORTS - 1);
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_enc   <= w_enc_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign grant_o       = r_grant;
    assign grant_enc_o   = r_enc;
    assign grant_valid_o = |r_grant;
    assign refresh_o     = (r_state == ST_REFRESH);

endmodule

// File: tb/tb_sdram_port_sched.sv
// Randomised scoreboard bench for sdram_port_sched against a behavioural owner/refresh model.
module tb_sdram_port_sched;

    localparam int P  = 3;
    localparam int Q  = 4;
    localparam int RC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] req;
    logic         ack, idle, rack;
    logic [P-1:0] grant;
    logic [1:0]   enc;
    logic         gv, refr, late;

    always #5 clk = ~clk;

    sdram_port_sched #(
        .WB_PORTS       (P),
        .QUOTA          (Q),
        .REFRESH_CYCLES (RC)
    ) dut (
        .sdram_clk      (clk),
        .sdram_rst      (rst),
        .req_i          (req),
        .ack_i          (ack),
        .sdram_idle_i   (idle),
        .refresh_ack_i  (rack),
        .grant_o        (grant),
        .grant_enc_o    (enc),
        .grant_valid_o  (gv),
        .refresh_o      (refr),
        .refresh_late_o (late)
    );

    typedef struct {
        logic [P-1:0] grant;
        logic [1:0]   enc;
        logic         valid;
        logic         refresh;
        logic         late;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: who owns the interface (-1 = nobody), whether a refresh is in progress,
    // and the refresh interval bookkeeping.
    int m_owner, m_last, m_enc, m_count, m_timer;
    bit m_refresh, m_pending, m_late;

    function automatic bit coin(input int n);
        return ($urandom_range(n - 1, 0) == 0);
    endfunction

    function automatic int pick(input logic [P-1:0] r);
`ifdef SDRAM_SCHED_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= P; k++) begin
            int p;
            p = (m_last + k) % P;
`ifdef SDRAM_SCHED_PRIO0_EN
            if (p == 0) continue;
`endif
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit expire, rel, prio0, others;
        if (rst) begin
            m_owner = -1; m_refresh = 0; m_last = P - 1; m_enc = 0;
            m_count = 0;  m_timer = RC - 1; m_pending = 0; m_late = 0;
            return;
        end
        expire = (m_timer == 0);
        if (m_refresh) begin
            if (rack) m_refresh = 0;
        end else if (m_owner < 0) begin
            if (m_pending && idle) m_refresh = 1;
            else if (req != 0) begin
                m_owner = pick(req);
                m_enc   = m_owner;
                m_count = 0;
            end
        end else begin
`ifdef SDRAM_SCHED_PRIO0_EN
            prio0 = (m_owner == 0);
`else
            prio0 = 0;
`endif
            others = 0;
            for (int k = 0; k < P; k++)
                if (k != m_owner && req[k]) others = 1;
            rel = idle && (!req[m_owner] || m_pending ||
                           (Q != 0 && m_count >= Q && others && !prio0));
            if (ack && m_count < Q) m_count++;
            if (rel) begin
                if (!prio0) m_last = m_owner;
                m_owner = -1;
            end
        end
        m_late    = expire && m_pending;
        m_pending = expire ? 1'b1 : (rack ? 1'b0 : m_pending);
        m_timer   = expire ? RC - 1 : m_timer - 1;
    endtask

    task automatic push_expected();
        exp_t e;
        e.grant = '0;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.enc     = 2'(m_enc);
        e.valid   = (m_owner >= 0);
        e.refresh = m_refresh;
        e.late    = m_late;
        sb.push_back(e);
    endtask

    task automatic tick(input logic [P-1:0] r, input logic a, input logic i,
                        input logic ra, input logic rs);
        req = r; ack = a; idle = i; rack = ra; rst = rs;
        @(posedge clk);
        #1;
        model_step();
        push_expected();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("grant",     32'(grant), 32'(e.grant));
                chk("grant_enc", 32'(enc),   32'(e.enc));
                chk("grant_vld", 32'(gv),    32'(e.valid));
                chk("refresh",   32'(refr),  32'(e.refresh));
                chk("late",      32'(late),  32'(e.late));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; ack = 1'b0; idle = 1'b0; rack = 1'b0;
        repeat (2) tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
        // all ports requesting, controller always idle: rotation 0,1,2
        repeat (120) tick(3'b111, coin(2), 1'b1, m_refresh && coin(2), 1'b0);
        // port 1 held, port 2 toggled in blocks: quota yield vs keep
        for (int b = 0; b < 8; b++)
            repeat (40) tick({b[0], 1'b1, 1'b0}, coin(2), !coin(3), m_refresh && coin(2), 1'b0);
        // busy controller: refresh must wait for a burst boundary
        repeat (150) tick(3'b001, coin(2), coin(8), m_refresh && coin(2), 1'b0);
        // refresh never acknowledged: late pulses every interval
        repeat (40) tick(P'($urandom), coin(2), 1'b1, 1'b0, 1'b0);
        // prio scenario shape: 110 then port 0 joins mid-tenure
        repeat (3) tick(3'b110, 1'b0, 1'b1, m_refresh, 1'b0);
        repeat (6) tick(3'b111, 1'b1, coin(2), m_refresh, 1'b0);
        // reset in the middle of a tenure
        repeat (5) tick(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        // fully random traffic with occasional resets and stray refresh acks
        repeat (2000)
            tick(P'($urandom), coin(2), !coin(4),
                 m_refresh ? coin(3) : coin(20), coin(100));
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
